// File: rtl/conv1d_seq_pkg.sv
// Shared sizing, state encoding and tap-address helper for the conv1d sequencer.
package conv1d_seq_pkg;

  localparam int MAX_WIDTH     = 1024;
  localparam int MAX_CHANNELS  = 128;
  localparam int KERNEL_LENGTH = 8;
  localparam int PAD_LEFT      = 3;

  localparam int W_W        = $clog2(MAX_WIDTH + 1);
  localparam int D_W        = $clog2(MAX_CHANNELS + 1);
  localparam int OUT_ADDR_W = $clog2(MAX_WIDTH);
  localparam int IN_ADDR_W  = $clog2(MAX_WIDTH * MAX_CHANNELS);
  localparam int KW_ADDR_W  = $clog2(KERNEL_LENGTH * MAX_CHANNELS);
  localparam int FX_W       = $clog2(KERNEL_LENGTH);
  localparam int CH_W       = $clog2(MAX_CHANNELS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [IN_ADDR_W-1:0] in_addr;
    logic [KW_ADDR_W-1:0] kw_addr;
  } tap_t;

  // Padding taps (in_x outside [0, W)) report valid=0 and zero addresses.
  function automatic tap_t tap_calc(
    input logic [OUT_ADDR_W-1:0] out_x,
    input logic [FX_W-1:0]       fx,
    input logic [CH_W-1:0]       ch,
    input logic [W_W-1:0]        w,
    input logic [D_W-1:0]        d
  );
    tap_t t;
    int   in_x;
    in_x      = int'(out_x) - PAD_LEFT + int'(fx);
    t.valid   = (in_x >= 0) && (in_x < int'(w));
    t.in_addr = '0;
    t.kw_addr = '0;
    if (t.valid) begin
      t.in_addr = IN_ADDR_W'(in_x * int'(d) + int'(ch));
      t.kw_addr = KW_ADDR_W'(int'(fx) * int'(d) + int'(ch));
    end
    return t;
  endfunction

endpackage

// File: rtl/conv1d_mac_stage.sv
// MAC stage one cycle behind issue: sign-extend, add input offset, multiply, accumulate.
module conv1d_mac_stage
  import conv1d_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        flush,
  input  logic        clear,
  input  logic [7:0]  in_data,
  input  logic [7:0]  kw_data,
  input  logic [31:0] offset,
  output logic [31:0] acc
);

  logic        valid_reg;
  logic [31:0] acc_reg;
  logic [31:0] in_ext;
  logic [31:0] kw_ext;
  logic [31:0] prod;

  // The low 32 bits of a product are identical for signed and unsigned operands.
  assign in_ext = {{24{in_data[7]}}, in_data};
  assign kw_ext = {{24{kw_data[7]}}, kw_data};
  assign prod   = valid_reg ? kw_ext * (in_ext + offset) : 32'd0;
  assign acc    = acc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      acc_reg   <= 32'd0;
    end else begin
      valid_reg <= flush ? 1'b0 : issue_valid;
      if (flush || clear) begin
        acc_reg <= 32'd0;
      end else begin
        acc_reg <= acc_reg + prod;
      end
    end
  end

endmodule

// File: rtl/conv1d_sequencer.sv
// Sequenced conv1d controller: walks out_x / filter_x / channel, issues buffer reads,
// and writes acc+bias per output position.
module conv1d_sequencer
  import conv1d_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [W_W-1:0]        input_output_width,
  input  logic [D_W-1:0]        input_depth,
  input  logic [31:0]           input_offset,
  input  logic [31:0]           bias,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  in_rd_en,
  output logic [IN_ADDR_W-1:0]  in_rd_addr,
  input  logic [7:0]            in_rd_data,
  output logic                  kw_rd_en,
  output logic [KW_ADDR_W-1:0]  kw_rd_addr,
  input  logic [7:0]            kw_rd_data,
  output logic                  out_wr_en,
  output logic [OUT_ADDR_W-1:0] out_wr_addr,
  output logic [31:0]           out_wr_data
);

  localparam logic [W_W-1:0]  W_MAX   = W_W'(MAX_WIDTH);
  localparam logic [D_W-1:0]  D_MAX   = D_W'(MAX_CHANNELS);
  localparam logic [FX_W-1:0] FX_LAST = FX_W'(KERNEL_LENGTH - 1);

  state_t                state_reg;
  logic [OUT_ADDR_W-1:0] out_x_reg, out_x_next;
  logic [FX_W-1:0]       fx_reg, fx_next;
  logic [CH_W-1:0]       ch_reg, ch_next;
  logic [W_W-1:0]        width_reg, width_next;
  logic [D_W-1:0]        depth_reg, depth_next;
  logic [31:0]           offset_reg;
  logic [31:0]           bias_reg;

  logic                  in_rd_en_reg, kw_rd_en_reg;
  logic [IN_ADDR_W-1:0]  in_rd_addr_reg;
  logic [KW_ADDR_W-1:0]  kw_rd_addr_reg;
  logic                  out_wr_en_reg;
  logic [OUT_ADDR_W-1:0] out_wr_addr_reg;
  logic                  busy_reg, done_reg, error_reg;

  logic                  params_bad;
  logic                  last_ch, last_fx, last_out;
  tap_t                  tap_next;
  logic [31:0]           acc;

  assign params_bad = (input_output_width == '0) || (input_depth == '0) ||
                      (input_output_width > W_MAX) || (input_depth > D_MAX);
  assign last_ch    = ({1'b0, ch_reg} == (depth_reg - 1'b1));
  assign last_fx    = (fx_reg == FX_LAST);
  assign last_out   = ({1'b0, out_x_reg} == (width_reg - 1'b1));

  // Position of the tap that will be on the read ports next cycle.
  always_comb begin
    out_x_next = out_x_reg;
    fx_next    = fx_reg;
    ch_next    = ch_reg;
    width_next = width_reg;
    depth_next = depth_reg;
    case (state_reg)
      ST_IDLE: begin
        out_x_next = '0;
        fx_next    = '0;
        ch_next    = '0;
        width_next = input_output_width;
        depth_next = input_depth;
      end
      ST_ISSUE: begin
        if (last_ch) begin
          fx_next = fx_reg + 1'b1;
          ch_next = '0;
        end else begin
          ch_next = ch_reg + 1'b1;
        end
      end
      ST_WRITE: begin
        out_x_next = out_x_reg + 1'b1;
        fx_next    = '0;
        ch_next    = '0;
      end
      default: ;
    endcase
    tap_next = tap_calc(out_x_next, fx_next, ch_next, width_next, depth_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      out_x_reg       <= '0;
      fx_reg          <= '0;
      ch_reg          <= '0;
      width_reg       <= '0;
      depth_reg       <= '0;
      offset_reg      <= 32'd0;
      bias_reg        <= 32'd0;
      in_rd_en_reg    <= 1'b0;
      in_rd_addr_reg  <= '0;
      kw_rd_en_reg    <= 1'b0;
      kw_rd_addr_reg  <= '0;
      out_wr_en_reg   <= 1'b0;
      out_wr_addr_reg <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      in_rd_en_reg    <= 1'b0;
      in_rd_addr_reg  <= '0;
      kw_rd_en_reg    <= 1'b0;
      kw_rd_addr_reg  <= '0;
      out_wr_en_reg   <= 1'b0;
      out_wr_addr_reg <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      if (abort) begin
        state_reg <= ST_IDLE;
        out_x_reg <= '0;
        fx_reg    <= '0;
        ch_reg    <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (params_bad) begin
                error_reg <= 1'b1;
              end else begin
                width_reg      <= input_output_width;
                depth_reg      <= input_depth;
                offset_reg     <= input_offset;
                bias_reg       <= bias;
                out_x_reg      <= out_x_next;
                fx_reg         <= fx_next;
                ch_reg         <= ch_next;
                in_rd_en_reg   <= tap_next.valid;
                kw_rd_en_reg   <= tap_next.valid;
                in_rd_addr_reg <= tap_next.in_addr;
                kw_rd_addr_reg <= tap_next.kw_addr;
                busy_reg       <= 1'b1;
                state_reg      <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            busy_reg <= 1'b1;
            if (last_ch && last_fx) begin
              state_reg <= ST_DRAIN;
            end else begin
              fx_reg         <= fx_next;
              ch_reg         <= ch_next;
              in_rd_en_reg   <= tap_next.valid;
              kw_rd_en_reg   <= tap_next.valid;
              in_rd_addr_reg <= tap_next.in_addr;
              kw_rd_addr_reg <= tap_next.kw_addr;
            end
          end
          ST_DRAIN: begin
            busy_reg        <= 1'b1;
            out_wr_en_reg   <= 1'b1;
            out_wr_addr_reg <= out_x_reg;
            state_reg       <= ST_WRITE;
          end
          ST_WRITE: begin
            if (last_out) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              busy_reg       <= 1'b1;
              out_x_reg      <= out_x_next;
              fx_reg         <= fx_next;
              ch_reg         <= ch_next;
              in_rd_en_reg   <= tap_next.valid;
              kw_rd_en_reg   <= tap_next.valid;
              in_rd_addr_reg <= tap_next.in_addr;
              kw_rd_addr_reg <= tap_next.kw_addr;
              state_reg      <= ST_ISSUE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  conv1d_mac_stage u_mac (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (in_rd_en_reg),
    .flush       (abort),
    .clear       (state_reg == ST_WRITE),
    .in_data     (in_rd_data),
    .kw_data     (kw_rd_data),
    .offset      (offset_reg),
    .acc         (acc)
  );

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;
  assign in_rd_en    = in_rd_en_reg;
  assign in_rd_addr  = in_rd_addr_reg;
  assign kw_rd_en    = kw_rd_en_reg;
  assign kw_rd_addr  = kw_rd_addr_reg;
  // A write coinciding with abort must not land.
  assign out_wr_en   = out_wr_en_reg && !abort;
  assign out_wr_addr = out_wr_addr_reg;
  assign out_wr_data = out_wr_en_reg ? (acc + bias_reg) : 32'd0;

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Directed testbench for conv1d_sequencer with behavioural buffer models.
`timescale 1ns/1ps
module tb_conv1d_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] input_output_width = '0;
  logic [7:0]  input_depth = '0;
  logic [31:0] input_offset = '0;
  logic [31:0] bias = '0;
  logic        busy, done, error;
  logic        in_rd_en, kw_rd_en, out_wr_en;
  logic [16:0] in_rd_addr;
  logic [9:0]  kw_rd_addr, out_wr_addr;
  logic [31:0] out_wr_data;
  logic [7:0]  in_rd_data = '0;
  logic [7:0]  kw_rd_data = '0;

  logic [7:0]  in_mem  [0:255];
  logic [7:0]  kw_mem  [0:255];
  logic [31:0] out_mem [0:15];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int wr_count = 0;
  int done_count = 0;
  int bad_reads = 0;
  int rd_limit = 256;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  conv1d_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .input_output_width(input_output_width), .input_depth(input_depth),
    .input_offset(input_offset), .bias(bias),
    .busy(busy), .done(done), .error(error),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .kw_rd_en(kw_rd_en), .kw_rd_addr(kw_rd_addr), .kw_rd_data(kw_rd_data),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (in_rd_en) in_rd_data <= in_mem[in_rd_addr[7:0]];
    if (kw_rd_en) kw_rd_data <= kw_mem[kw_rd_addr[7:0]];
  end

  always @(negedge clk) begin
    if (out_wr_en) begin
      if (out_wr_addr < 10'd16) out_mem[out_wr_addr[3:0]] = out_wr_data;
      wr_count++;
      $display("  write addr=%0d data=%0d", out_wr_addr, $signed(out_wr_data));
    end
    if (done) done_count++;
    if (in_rd_en && (int'(in_rd_addr) >= rd_limit)) bad_reads++;
  end

  task automatic clear_out();
    for (int i = 0; i < 16; i++) out_mem[i] = SENT;
  endtask

  task automatic launch(input int w, input int d, input int off, input int b, output int s);
    @(posedge clk); #1;
    input_output_width = 11'(w);
    input_depth = 8'(d);
    input_offset = 32'(off);
    bias = 32'(b);
    start = 1'b1;
    s = cycle;
    @(posedge clk); #1;
    start = 1'b0;
    input_output_width = 11'd7;
    input_depth = 8'd5;
    input_offset = 32'd99;
    bias = 32'd1000;
  endtask

  task automatic wait_done(input int s, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cycle - s;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, in_rd_en, kw_rd_en, out_wr_en} !== 6'b0)
      begin errors++; $display("FAIL reset_strobes got=%b exp=000000", {busy, done, error, in_rd_en, kw_rd_en, out_wr_en}); end
    checks++;
    if ({in_rd_addr, kw_rd_addr, out_wr_addr, out_wr_data} !== '0)
      begin errors++; $display("FAIL reset_buses got nonzero in=%0d kw=%0d oa=%0d od=%0d", in_rd_addr, kw_rd_addr, out_wr_addr, out_wr_data); end
    @(negedge clk);
    reset = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_basic(input string tag);
    int s, lat, w0, d0;
    for (int i = 0; i < 256; i++) begin in_mem[i] = 8'd1; kw_mem[i] = 8'd1; end
    clear_out();
    w0 = wr_count; d0 = done_count;
    launch(4, 1, 0, 5, s);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", tag, busy); end
    wait_done(s, 200, lat);
    checks++;
    if (lat != 41) begin errors++; $display("FAIL %s_latency got=%0d exp=41", tag, lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_in_done got=%b exp=0", tag, busy); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_mem[i] !== 32'd9) begin errors++; $display("FAIL %s_out%0d got=%0d exp=9", tag, i, out_mem[i]); end
    end
    checks++;
    if (wr_count - w0 != 4) begin errors++; $display("FAIL %s_writes got=%0d exp=4", tag, wr_count - w0); end
    checks++;
    if (done_count - d0 != 1) begin errors++; $display("FAIL %s_dones got=%0d exp=1", tag, done_count - d0); end
    $display("%s: W=4 D=1 latency=%0d", tag, lat);
  endtask

  task automatic test_offset();
    int s, lat;
    for (int i = 0; i < 256; i++) begin in_mem[i] = 8'h80; kw_mem[i] = 8'($urandom_range(1, 255)); end
    clear_out();
    bad_reads = 0;
    rd_limit = 6;
    launch(3, 2, 128, -7, s);
    wait_done(s, 200, lat);
    rd_limit = 256;
    checks++;
    if (lat != 3 * 18 + 1) begin errors++; $display("FAIL offset_latency got=%0d exp=55", lat); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_mem[i] !== 32'hFFFF_FFF9) begin errors++; $display("FAIL offset_out%0d got=%0d exp=-7", i, $signed(out_mem[i])); end
    end
    checks++;
    if (bad_reads != 0) begin errors++; $display("FAIL offset_range_reads got=%0d exp=0", bad_reads); end
    $display("offset: W=3 D=2 latency=%0d", lat);
  endtask

  task automatic test_taps();
    int s, lat;
    for (int i = 0; i < 256; i++) begin in_mem[i] = 8'd0; kw_mem[i] = 8'd0; end
    for (int i = 0; i < 6; i++) in_mem[i] = 8'(i + 1);
    for (int i = 9; i < 12; i++) kw_mem[i] = 8'd1;
    clear_out();
    launch(2, 3, 0, 0, s);
    wait_done(s, 200, lat);
    checks++;
    if (lat != 2 * 26 + 1) begin errors++; $display("FAIL taps_latency got=%0d exp=53", lat); end
    repeat (2) @(negedge clk);
    checks++;
    if (out_mem[0] !== 32'd6) begin errors++; $display("FAIL taps_out0 got=%0d exp=6", out_mem[0]); end
    checks++;
    if (out_mem[1] !== 32'd15) begin errors++; $display("FAIL taps_out1 got=%0d exp=15", out_mem[1]); end
    $display("taps: W=2 D=3 latency=%0d", lat);
  endtask

  task automatic test_param_error();
    int s, w0;
    w0 = wr_count;
    launch(4, 0, 0, 0, s);
    checks++;
    if ({error, busy} !== 2'b10) begin errors++; $display("FAIL err_d0 got error=%b busy=%b exp error=1 busy=0", error, busy); end
    @(posedge clk); #1;
    checks++;
    if ({error, busy} !== 2'b00) begin errors++; $display("FAIL err_d0_pulse got error=%b busy=%b exp 0 0", error, busy); end
    launch(1025, 1, 0, 0, s);
    checks++;
    if ({error, busy} !== 2'b10) begin errors++; $display("FAIL err_w1025 got error=%b busy=%b exp error=1 busy=0", error, busy); end
    launch(1, 128, 0, 0, s);
    checks++;
    if ({error, busy} !== 2'b01) begin errors++; $display("FAIL err_d128_ok got error=%b busy=%b exp error=0 busy=1", error, busy); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_count != w0) begin errors++; $display("FAIL err_no_activity got busy=%b writes=%0d exp busy=0 writes=0", busy, wr_count - w0); end
    $display("param_error: D=0, W=1025 rejected; W=1 D=128 accepted");
  endtask

  task automatic test_restart_ignored();
    int s, lat, d0, w0;
    for (int i = 0; i < 256; i++) begin in_mem[i] = 8'd1; kw_mem[i] = 8'd1; end
    clear_out();
    d0 = done_count; w0 = wr_count;
    launch(4, 1, 0, 5, s);
    repeat (10) @(posedge clk);
    #1;
    input_output_width = 11'd2; input_depth = 8'd1; bias = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(s, 200, lat);
    repeat (60) @(negedge clk);
    checks++;
    if (lat != 41) begin errors++; $display("FAIL restart_latency got=%0d exp=41", lat); end
    checks++;
    if (done_count - d0 != 1 || wr_count - w0 != 4) begin errors++; $display("FAIL restart_counts got dones=%0d writes=%0d exp 1 4", done_count - d0, wr_count - w0); end
    checks++;
    if (out_mem[3] !== 32'd9) begin errors++; $display("FAIL restart_out3 got=%0d exp=9", out_mem[3]); end
    $display("restart: mid-run start ignored, latency=%0d", lat);
  endtask

  task automatic test_abort();
    int s, d0, w0;
    clear_out();
    d0 = done_count; w0 = wr_count;
    launch(4, 1, 0, 20, s);
    repeat (19) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (out_wr_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_cycle got wr_en=%b busy=%b exp 0 1", out_wr_en, busy); end
    checks++;
    if (out_wr_addr !== 10'd1) begin errors++; $display("FAIL abort_in_write got addr=%0d exp=1", out_wr_addr); end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (40) @(negedge clk);
    checks++;
    if (done_count != d0 || wr_count - w0 != 1) begin errors++; $display("FAIL abort_counts got dones=%0d writes=%0d exp 0 1", done_count - d0, wr_count - w0); end
    checks++;
    if (out_mem[0] !== 32'd24 || out_mem[1] !== SENT) begin errors++; $display("FAIL abort_mem got out0=%0d out1=%h exp 24 deadbeef", out_mem[0], out_mem[1]); end
    @(posedge clk); #1;
    input_output_width = 11'd4; input_depth = 8'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, error} !== 2'b00) begin errors++; $display("FAIL abort_beats_start got busy=%b error=%b exp 0 0", busy, error); end
    $display("abort: out1 write suppressed, no done");
  endtask

  task automatic test_reset_midrun();
    int s;
    launch(4, 1, 0, 5, s);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (in_rd_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got rd_en=%b exp=1", in_rd_en); end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, in_rd_en, kw_rd_en, out_wr_en} !== 4'b0) begin errors++; $display("FAIL rst_mid_async got=%b exp=0000", {busy, in_rd_en, kw_rd_en, out_wr_en}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    $display("reset_midrun: outputs cleared asynchronously");
    test_basic("rerun");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin in_mem[i] = 8'd0; kw_mem[i] = 8'd0; end
    clear_out();
    test_reset();
    test_basic("basic");
    test_offset();
    test_taps();
    test_param_error();
    test_restart_ignored();
    test_abort();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
